ga_best_search: RTL and testbench
=================================

Name: ga_best_search

Overview:
Self-contained search engine for the genetic-algorithm datapath. Each enabled cycle it draws two pseudo-random 8-bit chromosomes from a seeded 32-bit LFSR and computes their fitness in one registered stage. It then keeps a running record of the fittest chromosome seen since reset. It sits between the RNG and the GA control logic and exposes the current best chromosome and its fitness.

Parameters:
FIT_WIDTH, 27, fitness width in bits (unsigned)
CHROM_WIDTH, 8, chromosome width in bits (unsigned)

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  synchronous, active-high; clears the pipeline and best record, loads the seed
seed  in  32  LFSR seed, sampled only while reset=1
enable  in  1  advance enable for LFSR, pipeline and best update; 0 = hold everything
enable_second  in  1  1 = both candidates compete; 0 = only candidate 1 considered
best  out  CHROM_WIDTH  fittest chromosome so far
best_fit  out  FIT_WIDTH  fitness of best
best_valid  out  1  1 once at least one candidate has been evaluated since reset

Behaviour:
- Reset (any clk edge with reset=1):
  - LFSR state <= seed; if seed==0, state <= 32'h0000_0001.
  - Stage-1 valid <= 0.
  - best <= 0, best_fit <= 0, best_valid <= 0.
  - Reset mid-operation discards all history.
- LFSR: Galois, 32-bit, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - Each enabled edge: state <= {1'b0, state[31:1]} ^ (state[0] ? mask : 0).
  - rnd1 = state[7:0]; rnd2 = state[15:8].
- Fitness: f(x) = 4*x^3 + x^2 + 1, unsigned, computed at full width then truncated to FIT_WIDTH.
  - With default parameters it never overflows: max f(255) = 66,390,526 < 2^27.
  - f is never 0.
- Stage 1, registered on an enabled edge with reset=0:
  - c1 <= rnd1, c2 <= rnd2, fit1 <= f(rnd1), fit2 <= f(rnd2), v1 <= 1.
- Stage 2 (best update), on an enabled edge with reset=0 and v1=1:
  - Candidate: if enable_second=1 and fit2 > fit1, use (c2, fit2); otherwise use (c1, fit1). Ties between candidates go to candidate 1.
  - If candidate fit > best_fit, load best/best_fit. Equal fitness keeps the incumbent.
  - best_valid <= 1.
  - enable_second is sampled at stage 2, in the same cycle as the compare.
- Latency: the LFSR state present at reset release reaches best/best_fit at the 2nd enabled edge after release.
- enable=0: all registers hold. No update occurs even if v1=1.
- best_fit is monotonic non-decreasing between resets.
- Outputs are driven directly from registers; no combinational path from inputs.

Decomposition:
- Package ga_pkg:
  - FIT_WIDTH/CHROM_WIDTH defaults.
  - LFSR_MASK = 32'h8020_0003.
  - LFSR_ZERO_SUB = 32'h1.
  - Function fitness(chrom) returning FIT_WIDTH bits.
- One sub-module, lfsr32_rng (clk, reset, enable, seed, rnd1, rnd2).
- Fitness evaluation and the best-compare logic stay inline in ga_best_search.

Test Plan:
- Seed 32'h0000_0001, enable=1, enable_second=1, release reset → after 2 edges: best=8'h01, best_fit=6, best_valid=1. Before that edge best_valid=0 and best=0.
- Seed 32'h0000_0000 → identical behaviour to seed 32'h1, confirming zero-seed substitution.
- Seed 32'h0000_FF02, enable_second=1 → best=8'hFF, best_fit=66,390,526. With enable_second=0 and the same seed → best=8'h02, best_fit=37.
- Seed 32'h0000_0303 (tie, both candidates 8'h03, f=118) → best=8'h03 taken from candidate 1. Later equal-fitness candidates do not change best.
- Run 200 cycles from seed 32'hCDE5_A1EF against a reference model of LFSR+f → best/best_fit match every cycle and best_fit never decreases. Drop enable for 5 cycles → all outputs frozen.
- Assert reset for 1 cycle mid-run → next edge best=0, best_fit=0, best_valid=0. Recovery follows the 2-edge latency from the reloaded seed.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared constants and the fitness function for the GA best-chromosome search.
package ga_pkg;

  localparam int DEF_FIT_WIDTH   = 27;
  localparam int DEF_CHROM_WIDTH = 8;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  // f(x) = 4x^3 + x^2 + 1; 32 bits hold f(255) exactly, so truncation is lossless
  function automatic logic [DEF_FIT_WIDTH-1:0] fitness(input logic [DEF_CHROM_WIDTH-1:0] chrom);
    logic [31:0] x;
    x = 32'(chrom);
    return DEF_FIT_WIDTH'((32'd4 * x * x * x) + (x * x) + 32'd1);
  endfunction

endpackage

// File: rtl/lfsr32_rng.sv
// Seeded 32-bit Galois LFSR supplying two 8-bit random draws per cycle.
module lfsr32_rng
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] seed,
  output logic [7:0]  rnd1,
  output logic [7:0]  rnd2
);

  logic [31:0] state;

  // An all-zero state would lock up, so a zero seed is replaced
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
    end else if (enable) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);
    end
  end

  assign rnd1 = state[7:0];
  assign rnd2 = state[15:8];

endmodule

// File: rtl/ga_best_search.sv
// Draws two chromosomes per enabled cycle, scores them one stage later and
// keeps the fittest chromosome seen since reset.
module ga_best_search
  import ga_pkg::*;
#(
  parameter int FIT_WIDTH   = DEF_FIT_WIDTH,
  parameter int CHROM_WIDTH = DEF_CHROM_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            seed,
  input  logic                   enable,
  input  logic                   enable_second,
  output logic [CHROM_WIDTH-1:0] best,
  output logic [FIT_WIDTH-1:0]   best_fit,
  output logic                   best_valid
);

  logic [7:0]             rnd1;
  logic [7:0]             rnd2;
  logic [CHROM_WIDTH-1:0] c1;
  logic [CHROM_WIDTH-1:0] c2;
  logic [FIT_WIDTH-1:0]   fit1;
  logic [FIT_WIDTH-1:0]   fit2;
  logic                   v1;
  logic [CHROM_WIDTH-1:0] cand;
  logic [FIT_WIDTH-1:0]   cand_fit;

  lfsr32_rng u_rng (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .seed   (seed),
    .rnd1   (rnd1),
    .rnd2   (rnd2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      c1   <= '0;
      c2   <= '0;
      fit1 <= '0;
      fit2 <= '0;
      v1   <= 1'b0;
    end else if (enable) begin
      c1   <= CHROM_WIDTH'(rnd1);
      c2   <= CHROM_WIDTH'(rnd2);
      fit1 <= FIT_WIDTH'(fitness(rnd1));
      fit2 <= FIT_WIDTH'(fitness(rnd2));
      v1   <= 1'b1;
    end
  end

  // Candidate 2 must be strictly fitter to win; ties stay with candidate 1
  always_comb begin
    cand     = c1;
    cand_fit = fit1;
    if (enable_second && (fit2 > fit1)) begin
      cand     = c2;
      cand_fit = fit2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best       <= '0;
      best_fit   <= '0;
      best_valid <= 1'b0;
    end else if (enable && v1) begin
      if (cand_fit > best_fit) begin
        best     <= cand;
        best_fit <= cand_fit;
      end
      best_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ga_best_search.sv
// Bench for ga_best_search: a running-maximum model checked every cycle plus
// hand-computed literal expectations.
module tb_ga_best_search;

  logic        clk;
  logic        reset;
  logic [31:0] seed;
  logic        enable;
  logic        enable_second;
  logic [7:0]  best;
  logic [26:0] best_fit;
  logic        best_valid;

  int total;
  int passed;

  ga_best_search dut (
    .clk           (clk),
    .reset         (reset),
    .seed          (seed),
    .enable        (enable),
    .enable_second (enable_second),
    .best          (best),
    .best_fit      (best_fit),
    .best_valid    (best_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: fitness by plain arithmetic, a queue of drawn pairs, running maximum
  function automatic longint f(input int x);
    return 4 * longint'(x) * x * x + longint'(x) * x + 1;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  logic [15:0] exp_q[$];
  logic [31:0] m_lfsr;
  int          m_best;
  longint      m_fit;
  bit          m_valid;
  bit          m_started;
  bit          m_fresh;

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr    = (seed == 32'h0) ? 32'h1 : seed;
      exp_q     = {};
      m_best    = 0;
      m_fit     = 0;
      m_valid   = 0;
      m_started = 1;
      m_fresh   = 1;
    end else if (enable) begin
      if (exp_q.size() > 0) begin
        logic [15:0] pair;
        int          a;
        int          b;
        int          pick;
        pair = exp_q.pop_front();
        a    = int'(pair[7:0]);
        b    = int'(pair[15:8]);
        pick = (enable_second && f(b) > f(a)) ? b : a;
        if (f(pick) > m_fit) begin
          m_best = pick;
          m_fit  = f(pick);
        end
        m_valid = 1;
      end
      exp_q.push_back(m_lfsr[15:0]);
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // compare process, sampled on the falling edge
  longint prev_fit;
  always @(negedge clk) begin
    if (m_started) begin
      check("best", 64'(best), 64'(m_best));
      check("best_fit", 64'(best_fit), 64'(m_fit));
      check("best_valid", 64'(best_valid), 64'(m_valid));
      if (!m_fresh) check("monotonic", 64'(best_fit >= 27'(prev_fit)), 64'd1);
      prev_fit = longint'(best_fit);
      m_fresh  = 0;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] s);
    reset = 1'b1;
    seed  = s;
    step(1);
    reset = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int b, input longint fv, input bit v);
    check({tag, ".best"}, 64'(best), 64'(b));
    check({tag, ".fit"}, 64'(best_fit), 64'(fv));
    check({tag, ".valid"}, 64'(best_valid), 64'(v));
  endtask

  initial begin
    total = 0;
    passed = 0;
    m_started = 0;
    m_fresh = 1;
    reset = 1'b1;
    seed = 32'h1;
    enable = 1'b1;
    enable_second = 1'b1;
    step(1);

    // seed 1: draws (01,00) then (03,00)
    do_reset(32'h0000_0001);
    expect_out("seed1_reset", 0, 0, 0);
    step(1);
    expect_out("seed1_edge1", 0, 0, 0);
    step(1);
    expect_out("seed1_edge2", 8'h01, 6, 1);
    step(1);
    expect_out("seed1_edge3", 8'h03, 118, 1);

    do_reset(32'h0000_0000);
    step(2);
    expect_out("seed0_edge2", 8'h01, 6, 1);

    enable_second = 1'b1;
    do_reset(32'h0000_FF02);
    step(2);
    expect_out("ff02_both", 8'hFF, 66390526, 1);

    enable_second = 1'b0;
    do_reset(32'h0000_FF02);
    step(2);
    expect_out("ff02_first", 8'h02, 37, 1);

    enable_second = 1'b1;
    do_reset(32'h0000_0303);
    step(2);
    expect_out("tie_0303", 8'h03, 118, 1);
    step(4);

    // long run with enable_second varied, then a frozen window
    do_reset(32'hCDE5_A1EF);
    for (int i = 0; i < 200; i++) begin
      enable_second = (i % 5 != 3);
      step(1);
    end
    enable_second = 1'b1;
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(10);

    // reset mid-run
    reset = 1'b1;
    seed  = 32'h0000_0001;
    step(1);
    expect_out("midrst", 0, 0, 0);
    reset = 1'b0;
    step(1);
    expect_out("midrst_edge1", 0, 0, 0);
    step(1);
    expect_out("midrst_edge2", 8'h01, 6, 1);
    step(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
